// File: rtl/slc3_button_sequencer_if.sv
// rtl/slc3_button_sequencer_if.sv - host-side control and CPU button bus of the SLC-3 button sequencer
interface slc3_button_sequencer_if #(
  parameter int SW_WIDTH = 10,
  parameter int CNT_W    = 8
);
  logic                start;
  logic                abort;
  logic                mode;
  logic                step_req;
  logic [CNT_W-1:0]    num_steps;
  logic [SW_WIDTH-1:0] sw_val;
  logic [SW_WIDTH-1:0] SW;
  logic                Run;
  logic                Continue;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    steps_done;

  modport master (
    output start, abort, mode, step_req, num_steps, sw_val,
    input  SW, Run, Continue, busy, done, steps_done
  );

  modport slave (
    input  start, abort, mode, step_req, num_steps, sw_val,
    output SW, Run, Continue, busy, done, steps_done
  );
endinterface

// File: rtl/slc3_button_sequencer.sv
// rtl/slc3_button_sequencer.sv - cycle-exact SW/Run/Continue driver for the SLC-3 top level
module slc3_button_sequencer #(
  parameter int SW_WIDTH   = 10,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int PRESS_CYC  = 1,
  parameter int GAP_CYC    = 1
) (
  input logic                    Clk,
  input logic                    Reset,
  slc3_button_sequencer_if.slave bus
);

  localparam int TMAX_A = (SETTLE_CYC > PRESS_CYC) ? SETTLE_CYC : PRESS_CYC;
  localparam int TMAX   = (TMAX_A > GAP_CYC) ? TMAX_A : GAP_CYC;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] PRESS_LAST  = TW'(PRESS_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_SW, RUN_PRESS, RUN_GAP, CONT_WAIT, CONT_PRESS, CONT_GAP, DONE
  } state_t;

  state_t              state;
  logic [TW-1:0]       tmr;
  logic [CNT_W-1:0]    num_lat;
  logic                mode_lat;
  logic [SW_WIDTH-1:0] sw_q;
  logic                run_q;
  logic                cont_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    steps_q;

  assign bus.SW         = sw_q;
  assign bus.Run        = run_q;
  assign bus.Continue   = cont_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps_done = steps_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      tmr      <= '0;
      num_lat  <= '0;
      mode_lat <= 1'b0;
      sw_q     <= '0;
      run_q    <= 1'b1;
      cont_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      steps_q  <= '0;
    end else if (bus.abort && state != IDLE) begin
      // Abort outranks step_req and completion; steps_done keeps its count.
      state  <= IDLE;
      tmr    <= '0;
      run_q  <= 1'b1;
      cont_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            num_lat  <= bus.num_steps;
            mode_lat <= bus.mode;
            sw_q     <= bus.sw_val;
            steps_q  <= '0;
            busy_q   <= 1'b1;
            tmr      <= '0;
            state    <= LOAD_SW;
          end
        end
        LOAD_SW: begin
          if (tmr == SETTLE_LAST) begin
            tmr   <= '0;
            run_q <= 1'b0;
            state <= RUN_PRESS;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RUN_PRESS: begin
          if (tmr == PRESS_LAST) begin
            tmr   <= '0;
            run_q <= 1'b1;
            state <= RUN_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        // steps_q is still zero in RUN_GAP, so one exit test serves both gaps.
        RUN_GAP, CONT_GAP: begin
          if (tmr == GAP_LAST) begin
            tmr <= '0;
            if (steps_q == num_lat) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else if (mode_lat) begin
              state <= CONT_WAIT;
            end else begin
              cont_q <= 1'b0;
              state  <= CONT_PRESS;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        CONT_WAIT: begin
          if (bus.step_req) begin
            cont_q <= 1'b0;
            state  <= CONT_PRESS;
          end
        end
        CONT_PRESS: begin
          if (tmr == PRESS_LAST) begin
            tmr     <= '0;
            cont_q  <= 1'b1;
            steps_q <= steps_q + 1'b1;
            state   <= CONT_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_button_sequencer.sv
// tb/tb_slc3_button_sequencer.sv - directed self-checking bench for slc3_button_sequencer
module tb_slc3_button_sequencer;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;
  int   len;
  int   presses;
  int   run_lows;

  slc3_button_sequencer_if #(.SW_WIDTH(10), .CNT_W(8)) if0 ();
  slc3_button_sequencer_if #(.SW_WIDTH(10), .CNT_W(4)) if1 ();

  slc3_button_sequencer u0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if0)
  );

  slc3_button_sequencer #(
    .SW_WIDTH(10), .CNT_W(4), .SETTLE_CYC(4), .PRESS_CYC(3), .GAP_CYC(2)
  ) u1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b0;
    if0.start = 0; if0.abort = 0; if0.mode = 0; if0.step_req = 0; if0.num_steps = '0; if0.sw_val = '0;
    if1.start = 0; if1.abort = 0; if1.mode = 0; if1.step_req = 0; if1.num_steps = '0; if1.sw_val = '0;
    repeat (2) @(negedge Clk);

    chk("rst_sw", if0.SW, 0);
    chk("rst_run", if0.Run, 1);
    chk("rst_cont", if0.Continue, 1);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_steps", if0.steps_done, 0);
    Reset = 1'b1;

    // reset asserted while Run is pressed
    if0.sw_val = 10'h1F1; if0.num_steps = 8'd3; if0.start = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      if (c == 1) if0.start = 0;
    end
    chk("t1_run_pressed", if0.Run, 0);
    #2 Reset = 1'b0;
    #1;
    chk("t1_async_run", if0.Run, 1);
    chk("t1_async_sw", if0.SW, 0);
    chk("t1_async_busy", if0.busy, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("t1_idle_busy", if0.busy, 0);
    chk("t1_idle_run", if0.Run, 1);
    chk("t1_idle_sw", if0.SW, 0);

    // burst of 3 with default timing; inputs wiggled mid-run must not matter
    if0.sw_val = 10'h00B; if0.num_steps = 8'd3; if0.mode = 0; if0.start = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 1) begin if0.start = 0; if0.sw_val = 10'h3FF; if0.num_steps = 8'd9; end
      chk("t2_sw", if0.SW, 10'h00B);
      chk("t2_run", if0.Run, (c == 3) ? 0 : 1);
      chk("t2_cont", if0.Continue, (c == 5 || c == 7 || c == 9) ? 0 : 1);
      chk("t2_done", if0.done, (c == 11) ? 1 : 0);
      chk("t2_busy", if0.busy, (c <= 11) ? 1 : 0);
    end
    chk("t2_steps", if0.steps_done, 3);

    // zero Continue presses
    if0.sw_val = 10'h2A5; if0.num_steps = 8'd0; if0.start = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        if0.start = 0;
        chk("t3_steps_clr", if0.steps_done, 0);
      end
      chk("t3_run", if0.Run, (c == 3) ? 0 : 1);
      chk("t3_cont", if0.Continue, 1);
      chk("t3_done", if0.done, (c == 5) ? 1 : 0);
      chk("t3_busy", if0.busy, (c <= 5) ? 1 : 0);
    end
    chk("t3_steps", if0.steps_done, 0);
    chk("t3_sw_kept", if0.SW, 10'h2A5);

    // single-step, step_req sampled at the end of cycles 8 and 18
    if0.sw_val = 10'h155; if0.num_steps = 8'd2; if0.mode = 1; if0.start = 1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge Clk);
      if (c == 1) if0.start = 0;
      if (c == 12) if0.mode = 0;
      if0.step_req = (c == 8 || c == 18);
      chk("t4_run", if0.Run, (c == 3) ? 0 : 1);
      chk("t4_cont", if0.Continue, (c == 9 || c == 19) ? 0 : 1);
      chk("t4_done", if0.done, (c == 21) ? 1 : 0);
      chk("t4_busy", if0.busy, (c <= 21) ? 1 : 0);
      if (c == 15) chk("t4_steps_mid", if0.steps_done, 1);
    end
    if0.step_req = 0;
    chk("t4_steps", if0.steps_done, 2);

    // abort during the second press, plus a start while busy
    if0.sw_val = 10'h0AA; if0.num_steps = 8'd5; if0.mode = 0; if0.start = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 1) if0.start = 0;
      if (c == 2) begin if0.start = 1; if0.sw_val = 10'h3C3; if0.num_steps = 8'd0; end
      if (c == 3) if0.start = 0;
      if0.abort = (c == 7);
      chk("t5_sw", if0.SW, 10'h0AA);
      chk("t5_done", if0.done, 0);
      chk("t5_run", if0.Run, (c == 3) ? 0 : 1);
      chk("t5_cont", if0.Continue, (c == 5 || c == 7) ? 0 : 1);
      chk("t5_busy", if0.busy, (c <= 7) ? 1 : 0);
      if (c >= 8) chk("t5_steps", if0.steps_done, 1);
    end

    // abort together with start in IDLE: start wins
    if0.sw_val = 10'h155; if0.num_steps = 8'd0; if0.start = 1; if0.abort = 1;
    @(negedge Clk);
    if0.start = 0; if0.abort = 0;
    chk("t5_start_wins_busy", if0.busy, 1);
    chk("t5_start_wins_sw", if0.SW, 10'h155);
    repeat (6) @(negedge Clk);
    chk("t5_start_wins_end", if0.busy, 0);

    // non-default timing, full-scale count
    if1.sw_val = 10'h02D; if1.num_steps = 4'hF; if1.mode = 0; if1.start = 1;
    len = 0; presses = 0; run_lows = 0;
    for (int c = 1; c <= 86; c++) begin
      @(negedge Clk);
      if (c == 1) if1.start = 0;
      chk("t6_done", if1.done, (c == 85) ? 1 : 0);
      chk("t6_busy", if1.busy, (c <= 85) ? 1 : 0);
      chk("t6_excl", (if1.Run == 1'b0 && if1.Continue == 1'b0) ? 1 : 0, 0);
      if (if1.Run == 1'b0) run_lows++;
      if (if1.Continue == 1'b0) begin
        len++;
      end else if (len != 0) begin
        chk("t6_press_len", len, 3);
        presses++;
        len = 0;
      end
    end
    chk("t6_run_len", run_lows, 3);
    chk("t6_presses", presses, 15);
    chk("t6_steps", if1.steps_done, 15);
    chk("t6_sw", if1.SW, 10'h02D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slc3_button_sequencer.md
Name: slc3_button_sequencer

Overview:
Parametrised hardware stimulus driver for the SLC-3 top level. It replaces hand-toggled Run/Continue sequences with a programmable, cycle-exact sequence:
- load switch value,
- press Run,
- issue N Continue presses, either in burst or in externally paced single-step mode.

It sits between a bench/host controller and the SW, Run and Continue inputs of the SLC-3 top level. Buttons are active-low: idle high, pressed low.

Parameters:
SW_WIDTH, 10, width of SW bus driven to the CPU.
CNT_W, 8, width of step count and step counter.
SETTLE_CYC, 2, cycles SW is held stable before Run is pressed (>=1).
PRESS_CYC, 1, cycles each button is held low (>=1).
GAP_CYC, 1, cycles each button is held high after a press (>=1).

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
start  in  1  begin sequence; sampled only in IDLE.
abort  in  1  terminate sequence; returns to IDLE with buttons released.
mode  in  1  0 = burst Continue presses; 1 = single-step, each press waits for step_req.
step_req  in  1  single-step advance request; sampled only in CONT_WAIT.
num_steps  in  CNT_W  number of Continue presses; latched at start.
sw_val  in  SW_WIDTH  switch value; latched at start.
SW  out  SW_WIDTH  switch bus to CPU.
Run  out  1  active-low Run button.
Continue  out  1  active-low Continue button.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on normal completion.
steps_done  out  CNT_W  Continue presses completed in the current or last sequence.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; SW=0; Run=1; Continue=1; busy=0; done=0; steps_done=0; internal counters=0.
  - Reset asserted mid-sequence forces these values immediately, without waiting for a clock edge.
- All outputs are registered (Moore, decoded from registered state); no combinational input-to-output paths.
- States: IDLE, LOAD_SW, RUN_PRESS, RUN_GAP, CONT_WAIT, CONT_PRESS, CONT_GAP, DONE.
- IDLE:
  - start=1 at an edge -> latch sw_val, num_steps and mode.
  - Clear steps_done; go to LOAD_SW.
  - SW drives the latched value from that edge onward.
- LOAD_SW: hold SETTLE_CYC cycles -> RUN_PRESS.
- RUN_PRESS: Run=0 for PRESS_CYC cycles -> RUN_GAP.
- RUN_GAP: Run=1 for GAP_CYC cycles. Then:
  - if latched num_steps==0 -> DONE;
  - else if mode=1 -> CONT_WAIT;
  - else -> CONT_PRESS.
- CONT_WAIT: Continue=1; step_req=1 at an edge -> CONT_PRESS; otherwise hold indefinitely.
- CONT_PRESS: Continue=0 for PRESS_CYC cycles -> CONT_GAP. steps_done increments on the CONT_PRESS->CONT_GAP edge.
- CONT_GAP: Continue=1 for GAP_CYC cycles. Then:
  - if steps_done==latched num_steps -> DONE;
  - else if mode=1 -> CONT_WAIT;
  - else -> CONT_PRESS.
- DONE: done=1 for exactly one cycle -> IDLE. SW keeps its value until the next start.
- Burst latency: with start sampled at edge t, done is high in cycle t+1+SETTLE_CYC+(PRESS_CYC+GAP_CYC)*(num_steps+1).
- start while busy: ignored; latched values are unchanged.
- Input changes after start: num_steps, sw_val and mode changes have no effect until the next start.
- abort:
  - abort=1 at an edge in any non-IDLE state -> IDLE next cycle; Run=1, Continue=1, done stays 0, steps_done frozen.
  - abort has priority over step_req and over completion in the same cycle.
  - abort in IDLE has no effect; abort and start together in IDLE -> start wins.
- Maximum count: num_steps = 2^CNT_W-1 is valid. steps_done never wraps, because it stops at the latched count.
- Run and Continue are never low in the same cycle; there is always at least one high cycle (GAP_CYC) between consecutive presses.

Test Plan:
1. Reset mid-sequence:
   - Stimulus: Reset=0 while in RUN_PRESS.
   - Required: Run=1, SW=0, busy=0 immediately, before the next Clk edge; after release, the block idles.
2. Burst, defaults:
   - Stimulus: sw_val=10'h00B, num_steps=3, mode=0, start at edge 0.
   - Required: SW=00B from cycle 1; Run low cycle 3; Continue low cycles 5, 7, 9; done high cycle 11; steps_done=3; busy low cycle 12.
3. num_steps=0:
   - Stimulus: start with num_steps=0.
   - Required: one Run press, no Continue press; done at cycle 1+2+2=5; steps_done=0.
4. Single-step:
   - Stimulus: mode=1, num_steps=2; step_req asserted 10 cycles apart.
   - Required: Continue stays high in CONT_WAIT; each step_req yields exactly one low Continue cycle starting the next cycle; done after the second press's gap.
5. Abort and ignored start:
   - Stimulus: abort during the second CONT_PRESS of a num_steps=5 burst.
   - Required: Continue=1 next cycle, done never pulses, steps_done=1.
   - Stimulus: start pulse while busy with a new sw_val.
   - Required: SW value unchanged.
6. Parameter sweep:
   - Stimulus: SETTLE_CYC=4, PRESS_CYC=3, GAP_CYC=2, CNT_W=4, num_steps=15.
   - Required: done at cycle 1+4+5*16=85; steps_done=15; each press exactly 3 cycles low.
